// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light front end: light encodings and
// default timing parameters for the sensor conditioner.
package traffic_pkg;

  localparam logic [1:0] LIGHT_OFF   = 2'b00;
  localparam logic [1:0] LIGHT_NORTH = 2'b01;
  localparam logic [1:0] LIGHT_WEST  = 2'b10;

  localparam int LIGHT_WEST_BIT  = 1;
  localparam int LIGHT_NORTH_BIT = 0;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int STUCK_CYCLES_DEF    = 1024;

endpackage

// File: rtl/sensor_debounce.sv
// One sensor channel: two-flop synchronizer, debounce counter and debounced level.
// Optional stuck-high detector is enabled by SENSOR_STUCK_DET_EN.
module sensor_debounce
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
  parameter int STUCK_CYCLES    = STUCK_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic deb,
  output logic rise,
  output logic stuck
);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_deb;
  logic [CNT_W-1:0] r_cnt;
  logic             w_cnt_done;

  assign w_cnt_done = (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_deb   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      // any sample agreeing with the current level restarts the count
      if (r_sync2 == r_deb) begin
        r_cnt <= '0;
      end else if (w_cnt_done) begin
        r_deb <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign deb  = r_deb;
  // high in the cycle whose closing edge raises deb, so the request sets on that same edge
  assign rise = r_sync2 & ~r_deb & w_cnt_done;

`ifdef SENSOR_STUCK_DET_EN
  localparam int STK_W = $clog2(STUCK_CYCLES + 1);

  logic [STK_W-1:0] r_stk_cnt;
  logic [STK_W-1:0] w_stk_next;
  logic             r_stuck;

  always_comb begin
    w_stk_next = r_stk_cnt;
    if (!r_deb) begin
      w_stk_next = '0;
    end else if (r_stk_cnt != STK_W'(STUCK_CYCLES)) begin
      w_stk_next = r_stk_cnt + STK_W'(1);
    end else begin
      w_stk_next = r_stk_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stk_cnt <= '0;
      r_stuck   <= 1'b0;
    end else begin
      r_stk_cnt <= w_stk_next;
      r_stuck   <= (w_stk_next == STK_W'(STUCK_CYCLES));
    end
  end

  assign stuck = r_stuck;
`else
  assign stuck = 1'b0;
`endif

endmodule

// File: rtl/sensor_conditioner.sv
// Synchronizes/debounces the west and north vehicle sensors and holds sticky
// requests until the controller serves them. Stuck detection: SENSOR_STUCK_DET_EN.
module sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
  parameter int STUCK_CYCLES    = STUCK_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_w,
  input  logic       raw_n,
  input  logic [1:0] light,
  output logic       w,
  output logic       n,
  output logic       deb_w,
  output logic       deb_n,
  output logic [1:0] stuck
);

  logic w_rise_w;
  logic w_rise_n;
  logic w_stuck_w;
  logic w_stuck_n;
  logic w_next_w;
  logic w_next_n;
  logic r_w;
  logic r_n;

  sensor_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W),
    .STUCK_CYCLES    (STUCK_CYCLES)
  ) u_deb_w (
    .clk   (clk),
    .reset (reset),
    .raw   (raw_w),
    .deb   (deb_w),
    .rise  (w_rise_w),
    .stuck (w_stuck_w)
  );

  sensor_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W),
    .STUCK_CYCLES    (STUCK_CYCLES)
  ) u_deb_n (
    .clk   (clk),
    .reset (reset),
    .raw   (raw_n),
    .deb   (deb_n),
    .rise  (w_rise_n),
    .stuck (w_stuck_n)
  );

  // priority: stuck suppression, then serve-clear, then new arrival
  always_comb begin
    w_next_w = r_w;
    w_next_n = r_n;
    if (w_stuck_w || light[LIGHT_WEST_BIT]) begin
      w_next_w = 1'b0;
    end else if (w_rise_w) begin
      w_next_w = 1'b1;
    end else begin
      w_next_w = r_w;
    end
    if (w_stuck_n || light[LIGHT_NORTH_BIT]) begin
      w_next_n = 1'b0;
    end else if (w_rise_n) begin
      w_next_n = 1'b1;
    end else begin
      w_next_n = r_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_w <= 1'b0;
      r_n <= 1'b0;
    end else begin
      r_w <= w_next_w;
      r_n <= w_next_n;
    end
  end

  assign w     = r_w;
  assign n     = r_n;
  assign stuck = {w_stuck_w, w_stuck_n};

endmodule

// File: tb/tb_sensor_conditioner.sv
// Scoreboard bench for sensor_conditioner: expected {w,n,deb_w,deb_n,stuck} vectors
// are queued with a target cycle when stimulus is driven and compared at that cycle.
module tb_sensor_conditioner;

  logic       clk;
  logic       reset;
  logic       raw_w;
  logic       raw_n;
  logic [1:0] light;
  logic       w;
  logic       n;
  logic       deb_w;
  logic       deb_n;
  logic [1:0] stuck;

  typedef struct {
    int          cyc;
    string       tag;
    logic [5:0]  exp;
  } sb_t;

  sb_t sb_q[$];
  int  cyc;
  int  n_checks;
  int  n_errors;

  sensor_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .STUCK_CYCLES    (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .raw_w (raw_w),
    .raw_n (raw_n),
    .light (light),
    .w     (w),
    .n     (n),
    .deb_w (deb_w),
    .deb_n (deb_n),
    .stuck (stuck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // expected value observed after the k-th following rising edge (edge 0 is the next one)
  task automatic expect_after(input int k, input string tag, input logic [5:0] exp);
    sb_t e;
    e.cyc = cyc + 1 + k;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  always @(negedge clk) begin
    sb_t keep[$];
    keep = {};
    foreach (sb_q[i]) begin
      if (sb_q[i].cyc == cyc) begin
        chk(sb_q[i].tag, {26'd0, w, n, deb_w, deb_n, stuck}, {26'd0, sb_q[i].exp});
      end else begin
        keep.push_back(sb_q[i]);
      end
    end
    sb_q = keep;
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    raw_w = 1'b0;
    raw_n = 1'b0;
    light = 2'b00;
    @(negedge clk);
    expect_after(0, "reset", 6'b000000);
    step(1);
    reset = 1'b0;

`ifdef SENSOR_STUCK_DET_EN
    raw_n = 1'b1;
    expect_after(5, "stk_req", 6'b010100);
    expect_after(23, "stk_set", 6'b000101);
    step(26);
    raw_n = 1'b0;
    expect_after(4, "stk_hold", 6'b000101);
    expect_after(8, "stk_clr", 6'b000000);
    step(10);
`else
    // west arrival with lights off
    raw_w = 1'b1;
    expect_after(4, "w_pre", 6'b000000);
    expect_after(5, "w_req", 6'b101000);
    expect_after(50, "w_held", 6'b101000);
    step(51);

    // north green leaves west pending, west green clears it
    light = 2'b01;
    expect_after(0, "l01_keep", 6'b101000);
    step(1);
    light = 2'b10;
    expect_after(0, "l10_clr", 6'b001000);
    step(1);
    light = 2'b00;
    expect_after(2, "clr_hold", 6'b001000);
    step(4);

    // 3-sample north glitch is rejected
    raw_n = 1'b1;
    expect_after(6, "g3_rej", 6'b001000);
    expect_after(10, "g3_rej2", 6'b001000);
    step(3);
    raw_n = 1'b0;
    step(12);

    // 4-sample north pulse is accepted; falling deb keeps the request
    raw_n = 1'b1;
    expect_after(4, "p4_pre", 6'b001000);
    expect_after(5, "p4_req", 6'b011100);
    expect_after(12, "p4_fall", 6'b011000);
    step(4);
    raw_n = 1'b0;
    step(12);

    // west arrival during west green: served, no request
    raw_w = 1'b0;
    expect_after(8, "w_low", 6'b010000);
    step(10);
    light = 2'b10;
    raw_w = 1'b1;
    expect_after(4, "grn_pre", 6'b010000);
    expect_after(5, "grn_rise", 6'b011000);
    step(6);
    light = 2'b00;
    expect_after(3, "grn_hold", 6'b011000);
    step(4);

    // both pending, reset mid-debounce, then re-request with inputs held
    raw_w = 1'b0;
    step(10);
    raw_w = 1'b1;
    expect_after(5, "w_req2", 6'b111000);
    step(8);
    raw_n = 1'b1;
    step(2);
    reset = 1'b1;
    expect_after(0, "rst_mid", 6'b000000);
    step(1);
    reset = 1'b0;
    expect_after(4, "rr_pre", 6'b000000);
    expect_after(5, "rr_req", 6'b111100);
    step(7);

    // illegal light code clears both
    light = 2'b11;
    expect_after(0, "ill_clr", 6'b001100);
    step(1);
    light = 2'b00;
    expect_after(3, "ill_hold", 6'b001100);
    step(5);
`endif

    for (int t = 0; t < 100 && sb_q.size() > 0; t++) begin
      step(1);
    end
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
